i2c_cmd_sequencer: RTL and testbench

//  Walks a parameter-packed table of I2C transactions (e.g. USB hub status read, downstream-port config) and

---
 rtl/i2c_cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: walks a packed I2C command table through i2c_master, handling the start/busy handshake,
// retries on NACK or start timeout, and an idle gap between commands.
module i2c_cmd_sequencer #(
    parameter int                     NUM_CMDS      = 3,
    parameter logic [NUM_CMDS*45-1:0] CMD_TABLE     = '0,
    parameter int                     GAP_CYCLES    = 4800,
    parameter int                     MAX_RETRIES   = 3,
    parameter int                     START_TIMEOUT = 1024,
    parameter bit                     AUTO_START    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic [6:0]  i2c_address,
    output logic [31:0] i2c_write_data,
    output logic [2:0]  i2c_write_len,
    output logic [2:0]  i2c_read_len,
    output logic        i2c_start,
    input  logic        i2c_busy,
    input  logic        i2c_no_response,
    input  logic [31:0] i2c_read_data,
    output logic [3:0]  cmd_index,
    output logic [31:0] last_read_data,
    output logic        seq_busy,
    output logic        seq_done,
    output logic        seq_fail
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY_LOW, GAP, DONE, FAIL} state_t;
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_CMDS - 1);
    localparam logic [31:0] GAP_N     = 32'(GAP_CYCLES);
    localparam logic [31:0] TIMEOUT_N = 32'(START_TIMEOUT);
    localparam logic [31:0] RETRY_N   = 32'(MAX_RETRIES);
    state_t      state;
    logic        auto_pend, advance;
    logic [31:0] cnt, retries;
    logic [3:0]  nxt_idx;
    logic [44:0] entry;
    logic [2:0]  nxt_wlen, nxt_rlen;
    logic        nxt_skip, gap_end, last_done, launch, attempt_fail;
    always_comb begin
        gap_end      = cnt + 32'd1 >= GAP_N;
        last_done    = advance && cmd_index == LAST_IDX;
        nxt_idx      = state != GAP ? 4'd0 : (advance && cmd_index != LAST_IDX) ? cmd_index + 4'd1 : cmd_index;
        entry        = CMD_TABLE[int'(nxt_idx)*45 +: 45];
        nxt_wlen     = entry[37:35] > 3'd4 ? 3'd4 : entry[37:35];
        nxt_rlen     = entry[34:32] > 3'd4 ? 3'd4 : entry[34:32];
        nxt_skip     = entry[37:32] == 6'd0;
        launch       = (state == IDLE && (go || auto_pend)) || ((state == DONE || state == FAIL) && go) ||
                       (state == GAP && gap_end && !last_done);
        attempt_fail = (state == ISSUE && !i2c_busy && cnt + 32'd1 >= TIMEOUT_N) ||
                       (state == WAIT_BUSY_LOW && !i2c_busy && i2c_no_response);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            auto_pend      <= AUTO_START;
            advance        <= 1'b0;
            cnt            <= '0;
            retries        <= '0;
            cmd_index      <= '0;
            last_read_data <= '0;
            seq_busy       <= 1'b0;
            seq_done       <= 1'b0;
            seq_fail       <= 1'b0;
            i2c_start      <= 1'b0;
            i2c_address    <= '0;
            i2c_write_data <= '0;
            i2c_write_len  <= '0;
            i2c_read_len   <= '0;
        end else begin
            auto_pend <= 1'b0;
            case (state)
                ISSUE: begin
                    cnt <= cnt + 32'd1;
                    if (i2c_busy) begin
                        i2c_start <= 1'b0;
                        state     <= WAIT_BUSY_LOW;
                    end
                end
                WAIT_BUSY_LOW: if (!i2c_busy && !i2c_no_response) begin
                    if (i2c_read_len != 3'd0) last_read_data <= i2c_read_data;
                    retries <= '0;
                    advance <= 1'b1;
                    cnt     <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    cnt <= cnt + 32'd1;
                    if (gap_end && last_done) begin
                        state    <= DONE;
                        seq_busy <= 1'b0;
                        seq_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            if ((state == WAIT_BUSY_LOW && !i2c_busy) || attempt_fail) begin
                i2c_address    <= '0;
                i2c_write_data <= '0;
                i2c_write_len  <= '0;
                i2c_read_len   <= '0;
            end
            if (attempt_fail) begin
                i2c_start <= 1'b0;
                if (retries < RETRY_N) begin
                    retries <= retries + 32'd1;
                    advance <= 1'b0;
                    cnt     <= '0;
                    state   <= GAP;
                end else begin
                    state    <= FAIL;
                    seq_busy <= 1'b0;
                    seq_fail <= 1'b1;
                end
            end
            // Empty entries succeed without touching the bus but still take the gap.
            if (launch) begin
                cmd_index <= nxt_idx;
                cnt       <= '0;
                seq_busy  <= 1'b1;
                seq_done  <= 1'b0;
                seq_fail  <= 1'b0;
                if (state != GAP || nxt_skip) retries <= '0;
                if (nxt_skip) begin
                    state   <= GAP;
                    advance <= 1'b1;
                end else begin
                    state          <= ISSUE;
                    i2c_start      <= 1'b1;
                    i2c_address    <= entry[44:38];
                    i2c_write_data <= entry[31:0];
                    i2c_write_len  <= nxt_wlen;
                    i2c_read_len   <= nxt_rlen;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: randomized scoreboard bench; a behavioural i2c_master answers each start from a plan
// and a table-level model predicts every request, the gaps between them and the final status.
module tb_i2c_cmd_sequencer;
    localparam int N = 4, G = 4, MAXR = 2, TO = 16;
    localparam logic [N*45-1:0] TABLE = {7'h50, 3'd6, 3'd7, 32'hDEADBEEF, 7'h11, 3'd0, 3'd0, 32'h12345678,
                                         7'h2D, 3'd2, 3'd0, 32'h000005FF, 7'h2D, 3'd1, 3'd2, 32'h0000001C};
    logic clk = 1'b0, rst = 1'b1, go = 1'b0, i2c_busy = 1'b0, i2c_no_response = 1'b0;
    logic [31:0] i2c_read_data = '0;
    logic [6:0]  i2c_address;
    logic [31:0] i2c_write_data, last_read_data;
    logic [2:0]  i2c_write_len, i2c_read_len;
    logic [3:0]  cmd_index;
    logic        i2c_start, seq_busy, seq_done, seq_fail;
    always #5 clk = ~clk;
    i2c_cmd_sequencer #(.NUM_CMDS(N), .CMD_TABLE(TABLE), .GAP_CYCLES(G), .MAX_RETRIES(MAXR),
                        .START_TIMEOUT(TO), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .go(go), .i2c_address(i2c_address), .i2c_write_data(i2c_write_data),
        .i2c_write_len(i2c_write_len), .i2c_read_len(i2c_read_len), .i2c_start(i2c_start),
        .i2c_busy(i2c_busy), .i2c_no_response(i2c_no_response), .i2c_read_data(i2c_read_data),
        .cmd_index(cmd_index), .last_read_data(last_read_data), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_fail(seq_fail));
    typedef struct { int idx; logic [6:0] addr; logic [31:0] wdata; int wlen; int rlen; int gap; bit to; } req_t;
    typedef struct { int oc; logic [31:0] rd; } plan_t;
    typedef struct { bit done; bit fail; int idx; logic [31:0] lrd; } stat_t;
    req_t  exp_q[$];
    plan_t plan_q[$];
    stat_t stat_q[$];
    int n_chk = 0, n_pass = 0;
    logic [31:0] m_lrd = '0;
    logic [6:0]  m_addr [N] = '{7'h2D, 7'h2D, 7'h11, 7'h50};
    logic [31:0] m_wd   [N] = '{32'h1C, 32'h5FF, 32'h12345678, 32'hDEADBEEF};
    int          m_wl   [N] = '{1, 2, 0, 6};
    int          m_rl   [N] = '{2, 0, 0, 7};
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction
    task automatic finish_bench();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask
    // outcome per attempt: 0 ACK, 1 NACK, 2 busy never rises
    function automatic int pick(input int mode, input int e, input int att);
        int r;
        r = $urandom_range(0, 9);
        case (mode)
            1: return 0;
            2: return (e == 0 && att < 2) ? 1 : 0;
            3: return e == 1 ? 1 : 0;
            4: return 2;
            default: return r < 5 ? 0 : r < 8 ? 1 : 2;
        endcase
    endfunction
    task automatic build_run(input int mode);
        int extra = 0, oc;
        bit first = 1'b1, prev_to = 1'b0;
        req_t r;
        plan_t p;
        stat_t s;
        for (int e = 0; e < N; e++) begin
            if (m_wl[e] == 0 && m_rl[e] == 0) begin
                extra += G;
                continue;
            end
            for (int att = 0; att <= MAXR; att++) begin
                oc = pick(mode, e, att);
                p.oc = oc;
                p.rd = mode == 1 ? 32'hA55A : $urandom;
                r.idx = e; r.addr = m_addr[e]; r.wdata = m_wd[e];
                r.wlen = m_wl[e] > 4 ? 4 : m_wl[e];
                r.rlen = m_rl[e] > 4 ? 4 : m_rl[e];
                r.gap = first ? -1 : (prev_to ? G : G + 1) + extra;
                r.to = oc == 2;
                exp_q.push_back(r);
                plan_q.push_back(p);
                first = 1'b0; prev_to = oc == 2; extra = 0;
                if (oc == 0) begin
                    if (m_rl[e] != 0) m_lrd = p.rd;
                    break;
                end
                if (att == MAXR) begin
                    s.done = 1'b0; s.fail = 1'b1; s.idx = e; s.lrd = m_lrd;
                    stat_q.push_back(s);
                    return;
                end
            end
        end
        s.done = 1'b1; s.fail = 1'b0; s.idx = N - 1; s.lrd = m_lrd;
        stat_q.push_back(s);
    endtask
    // i2c_master stand-in
    initial begin
        int st = 0, cnt = 0;
        plan_t p;
        p.oc = 0; p.rd = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                i2c_busy = 1'b0; i2c_no_response = 1'b0; st = 0;
            end else case (st)
                0: if (i2c_start) begin
                    if (plan_q.size() != 0) p = plan_q.pop_front();
                    else begin p.oc = 0; p.rd = '0; end
                    if (p.oc == 2) st = 3;
                    else begin cnt = $urandom_range(0, 3); st = 1; end
                end
                1: if (cnt == 0) begin i2c_busy = 1'b1; cnt = $urandom_range(3, 6); st = 2; end
                   else cnt--;
                2: begin
                    cnt--;
                    if (cnt == 0) begin
                        i2c_busy = 1'b0; i2c_no_response = p.oc == 1; i2c_read_data = p.rd; st = 0;
                    end
                end
                default: if (!i2c_start) st = 0;
            endcase
        end
    end
    // monitor / scoreboard
    initial begin
        req_t cur;
        stat_t s;
        bit p_start = 1'b0, p_fin = 1'b0, fin;
        int hi_cnt = 0, low_cnt = 0;
        cur.to = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start === 1'b1 && !p_start) begin
                if (exp_q.size() == 0) chk("unexpected_start", 32'(cmd_index), 32'hFFFF_FFFF);
                else begin
                    cur = exp_q.pop_front();
                    chk("req_idx", 32'(cmd_index), 32'(cur.idx));
                    chk("req_addr", 32'(i2c_address), 32'(cur.addr));
                    chk("req_wdata", i2c_write_data, cur.wdata);
                    chk("req_wlen", 32'(i2c_write_len), 32'(cur.wlen));
                    chk("req_rlen", 32'(i2c_read_len), 32'(cur.rlen));
                    if (cur.gap >= 0) chk("req_gap", 32'(low_cnt), 32'(cur.gap));
                end
                hi_cnt = 0;
            end
            if (i2c_start === 1'b0 && p_start && cur.to) chk("start_timeout_len", 32'(hi_cnt), 32'(TO));
            if (i2c_start === 1'b1) hi_cnt++;
            low_cnt = (i2c_busy || i2c_start === 1'b1) ? 0 : low_cnt + 1;
            fin = (seq_done | seq_fail) === 1'b1;
            if (fin && !p_fin) begin
                if (stat_q.size() == 0) chk("unexpected_status", {seq_done, seq_fail}, 32'h0);
                else begin
                    s = stat_q.pop_front();
                    chk("st_done", 32'(seq_done), 32'(s.done));
                    chk("st_fail", 32'(seq_fail), 32'(s.fail));
                    chk("st_idx", 32'(cmd_index), 32'(s.idx));
                    chk("st_lrd", last_read_data, s.lrd);
                    chk("st_req_idle", 32'({seq_busy, i2c_start, i2c_address, i2c_write_len, i2c_read_len}), 32'h0);
                    chk("st_wdata_idle", i2c_write_data, 32'h0);
                    chk("st_all_consumed", 32'(exp_q.size()), 32'h0);
                end
            end
            p_start = i2c_start === 1'b1;
            p_fin = fin;
        end
    end
    task automatic check_reset_outputs();
        chk("rst_req", 32'({i2c_start, i2c_address, i2c_write_len, i2c_read_len}), 32'h0);
        chk("rst_wdata", i2c_write_data, 32'h0);
        chk("rst_status", 32'({cmd_index, seq_busy, seq_done, seq_fail}), 32'h0);
        chk("rst_lrd", last_read_data, 32'h0);
    endtask
    task automatic wait_status();
        int n = 0;
        while (stat_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (stat_q.size() != 0) begin
            chk("status_wait_expired", 32'(stat_q.size()), 32'h0);
            finish_bench();
        end
        repeat (5) @(negedge clk);
    endtask
    task automatic run(input int mode);
        build_run(mode);
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        chk("launch_flags", 32'({seq_busy, seq_done, seq_fail}), 32'h4);
        repeat (3) @(negedge clk);
        go = 1'b1;
        @(negedge clk) go = 1'b0;
        wait_status();
    endtask
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        build_run(1);
        @(negedge clk) rst = 1'b0;
        wait_status();
        run(2);
        run(3);
        run(4);
        build_run(1);
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        n = 0;
        while (!(i2c_busy && i2c_start === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_busy_low", 32'({i2c_busy, i2c_start}), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        plan_q.delete();
        stat_q.delete();
        m_lrd = '0;
        build_run(1);
        @(negedge clk) rst = 1'b0;
        wait_status();
        run(1);
        run(1);
        for (int i = 0; i < 8; i++) run(0);
        finish_bench();
    end
endmodule
